// File: rtl/instr_mem_pkg.sv
// Shared constants and default program image for the single-cycle ARM instruction memory.
package instr_mem_pkg;

    localparam int INSTR_W    = 32;
    localparam int IMEM_AW    = 8;
    localparam int IMEM_DEPTH = 256;

    localparam logic [INSTR_W-1:0] ARM_NOP = 32'hE1A0_0000;
    localparam logic [INSTR_W-1:0] PROG_0  = 32'hE3A0_0005;
    localparam logic [INSTR_W-1:0] PROG_1  = 32'hE3A0_1003;
    localparam logic [INSTR_W-1:0] PROG_2  = 32'hE080_2001;
    localparam logic [INSTR_W-1:0] PROG_3  = 32'hEAFF_FFFE;

    // Image word for one entry: a four-instruction demo program, then NOPs.
    function automatic logic [INSTR_W-1:0] default_word(input logic [IMEM_AW-1:0] idx);
        logic [INSTR_W-1:0] word;
        case (idx)
            8'd0:    word = PROG_0;
            8'd1:    word = PROG_1;
            8'd2:    word = PROG_2;
            8'd3:    word = PROG_3;
            default: word = ARM_NOP;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: combinational fetch, synchronous load port,
// synchronous reset back to the default program image.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      instr_ddr_in,
    output logic [INSTR_W-1:0] instruction_out,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data
);

    // Power-up contents match the reset image so fetch is defined before any clock.
    logic [INSTR_W-1:0] mem_r [DEPTH] = '{
        0:       default_word(8'd0),
        1:       default_word(8'd1),
        2:       default_word(8'd2),
        3:       default_word(8'd3),
        default: ARM_NOP
    };

    // Reset reloads the whole image and wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= default_word(IMEM_AW'(i));
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    // Zero-latency fetch; no bypass, so a same-address write shows only after the edge.
    assign instruction_out = mem_r[instr_ddr_in];

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed boundary cases plus randomized
// write/reset/read traffic against an array-based reference model.
module tb_instr_mem;

    logic        clk;
    logic        rst;
    logic [7:0]  instr_ddr_in;
    logic [31:0] instruction_out;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    int tests_run;
    int tests_failed;

    logic [31:0] image [256];
    logic [31:0] model [256];

    instr_mem dut (
        .clk             (clk),
        .rst             (rst),
        .instr_ddr_in    (instr_ddr_in),
        .instruction_out (instruction_out),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr);
        instr_ddr_in = addr;
        #1;
        check(tag, instruction_out, model[addr]);
    endtask

    // One clocked transaction: drive at negedge, update the model at the rising edge.
    task automatic cycle(input logic r, input logic we, input logic [7:0] wa,
                         input logic [31:0] wd);
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        if (r) model = image;
        else if (we) model[wa] = wd;
        #1;
        rst = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 256; i++) image[i] = 32'hE1A0_0000;
        image[0] = 32'hE3A0_0005;
        image[1] = 32'hE3A0_1003;
        image[2] = 32'hE080_2001;
        image[3] = 32'hEAFF_FFFE;
        model = image;

        rst = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 32'd0; instr_ddr_in = 8'd0;

        // Power-up, before the first clock edge at t=5.
        read_check("pwr_a0", 8'd0);
        read_check("pwr_a3", 8'd3);
        read_check("pwr_a200", 8'd200);

        // Reset then full address sweep, zero-cycle latency each step.
        cycle(1'b1, 1'b0, 8'd0, 32'd0);
        for (int a = 0; a < 256; a++) begin
            instr_ddr_in = 8'(a);
            #1;
            check("sweep", instruction_out, image[a]);
        end

        // Write then neighbours untouched.
        cycle(1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF);
        read_check("wr_0x10", 8'h10);
        check("wr_0x10_val", instruction_out, 32'hDEAD_BEEF);
        read_check("wr_0x0f", 8'h0F);
        read_check("wr_0x11", 8'h11);

        // Read-during-write at the same address: old before, new after.
        @(negedge clk);
        instr_ddr_in = 8'h20;
        rst = 1'b0; wr_en = 1'b1; wr_addr = 8'h20; wr_data = 32'h1234_5678;
        #1;
        check("rdw_before", instruction_out, 32'hE1A0_0000);
        @(posedge clk);
        model[8'h20] = 32'h1234_5678;
        #1;
        wr_en = 1'b0;
        check("rdw_after", instruction_out, 32'h1234_5678);

        // Reset priority over a simultaneous write.
        cycle(1'b1, 1'b1, 8'd1, 32'hFFFF_FFFF);
        read_check("rst_prio", 8'd1);
        check("rst_prio_val", instruction_out, 32'hE3A0_1003);

        // Reset restores an overwritten word; multi-cycle reset equals single.
        cycle(1'b0, 1'b1, 8'd0, 32'hCAFE_F00D);
        read_check("pre_rst_a0", 8'd0);
        cycle(1'b1, 1'b0, 8'd0, 32'd0);
        cycle(1'b1, 1'b0, 8'd0, 32'd0);
        read_check("rst_restore", 8'd0);
        check("rst_restore_val", instruction_out, 32'hE3A0_0005);

        // Randomized traffic with occasional mid-burst resets.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        we;
            logic [7:0]  wa;
            logic [31:0] wd;
            r  = ($urandom_range(0, 19) == 0);
            we = ($urandom_range(0, 3) != 0);
            wa = 8'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'd0);
            wd = 32'($urandom);
            @(negedge clk);
            instr_ddr_in = wa;
            rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
            #1;
            check("rnd_pre", instruction_out, model[wa]);
            @(posedge clk);
            if (r) model = image;
            else if (we) model[wa] = wd;
            #1;
            rst = 1'b0; wr_en = 1'b0;
            check("rnd_post", instruction_out, model[wa]);
            read_check("rnd_any", 8'($urandom));
        end

        // Final full comparison of the array contents.
        for (int a = 0; a < 256; a++) read_check("final", 8'(a));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
